// File: rtl/fifo_pkg.sv
// ----------------------------------------------------------------------------
// fifo_pkg
//  Shared constants and helpers for the sync_fifo block.
//  - DEFAULT_WIDTH / DEFAULT_DEPTH : default geometry of the FIFO.
//  - ptr_w(depth)                  : pointer width = address bits + 1 wrap bit.
// ----------------------------------------------------------------------------
package fifo_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 8;

    // One extra bit beyond the address lets full and empty be told apart
    // when the address bits of both pointers are equal.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage : fifo_pkg

// File: rtl/sync_fifo_if.sv
// ----------------------------------------------------------------------------
// sync_fifo_if
//  Bundles the producer/consumer side of sync_fifo.
//  Signals:
//    wr_en, data_in   : write request and write data (master -> fifo)
//    rd_en            : pop request (master -> fifo)
//    data_out         : head-of-queue word, first-word-fall-through (fifo -> master)
//    full, empty      : flow-control flags (fifo -> master)
//    count, overflow, underflow : status outputs, present only when the
//                       FIFO_STATUS_EN macro is defined.
//  Modports: master (producer/consumer), slave (the FIFO itself).
// ----------------------------------------------------------------------------
interface sync_fifo_if #(
    parameter int WIDTH = fifo_pkg::DEFAULT_WIDTH
`ifdef FIFO_STATUS_EN
    ,
    parameter int CNT_W = fifo_pkg::ptr_w(fifo_pkg::DEFAULT_DEPTH)
`endif
);

    logic             wr_en;
    logic             rd_en;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic             full;
    logic             empty;
`ifdef FIFO_STATUS_EN
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic             underflow;
`endif

    modport master (
        output wr_en,
        output rd_en,
        output data_in,
        input  data_out,
        input  full,
        input  empty
`ifdef FIFO_STATUS_EN
        ,
        input  count,
        input  overflow,
        input  underflow
`endif
    );

    modport slave (
        input  wr_en,
        input  rd_en,
        input  data_in,
        output data_out,
        output full,
        output empty
`ifdef FIFO_STATUS_EN
        ,
        output count,
        output overflow,
        output underflow
`endif
    );

endinterface : sync_fifo_if

// File: rtl/fifo_mem.sv
// ----------------------------------------------------------------------------
// fifo_mem
//  DEPTH x WIDTH storage array for sync_fifo.
//  Synchronous write port, asynchronous read port, no reset on the array.
//  Ports:
//    clk     : write clock
//    i_we    : write enable
//    i_waddr : write address
//    i_wdata : write data
//    i_raddr : read address
//    o_rdata : read data (combinational from the array)
// ----------------------------------------------------------------------------
module fifo_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [WIDTH-1:0]         o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Unregistered read so the head word is visible in the same cycle
    // the consumer pops it.
    assign o_rdata = r_mem[i_raddr];

endmodule : fifo_mem

// File: rtl/sync_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo
//  Single-clock FIFO with first-word-fall-through read.
//  Ports:
//    clk  : rising-edge clock
//    arst : asynchronous reset, active-high; empties the FIFO
//    bus  : sync_fifo_if.slave (wr_en, rd_en, data_in, data_out, full, empty
//           and, with FIFO_STATUS_EN, count/overflow/underflow)
//  Optional feature macro: FIFO_STATUS_EN
//    Adds occupancy count plus registered overflow/underflow pulses.
//  Writes while full and reads while empty are ignored.
// ----------------------------------------------------------------------------
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic     clk,
    input  logic     arst,
    sync_fifo_if.slave bus
);

    localparam int PTR_W  = ptr_w(DEPTH);
    localparam int ADDR_W = PTR_W - 1;

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("sync_fifo: DEPTH must be a power of two and at least 2");
        end
    endgenerate

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic             w_empty;
    logic             w_full;
    logic             w_wr_accept;
    logic             w_rd_accept;
    logic [WIDTH-1:0] w_head;

    // Equal pointers: nothing held. Same slot but opposite lap: all slots held.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0])
                  && (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]);

    // Gating on the current flags gives the required simultaneous behaviour:
    // full lets only the read through, empty lets only the write through.
    assign w_wr_accept = bus.wr_en && !w_full;
    assign w_rd_accept = bus.rd_en && !w_empty;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_accept) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_rd_accept) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
        end
    end

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_wr_accept),
        .i_waddr (r_wr_ptr[ADDR_W-1:0]),
        .i_wdata (bus.data_in),
        .i_raddr (r_rd_ptr[ADDR_W-1:0]),
        .o_rdata (w_head)
    );

    // Stale storage is masked so an empty FIFO always presents zero.
    assign bus.data_out = w_empty ? '0 : w_head;
    assign bus.full     = w_full;
    assign bus.empty    = w_empty;

`ifdef FIFO_STATUS_EN
    logic r_overflow;
    logic r_underflow;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= bus.wr_en && w_full;
            r_underflow <= bus.rd_en && w_empty;
        end
    end

    // Modulo-2*DEPTH difference of the pointers is the occupancy 0..DEPTH.
    assign bus.count     = r_wr_ptr - r_rd_ptr;
    assign bus.overflow  = r_overflow;
    assign bus.underflow = r_underflow;
`endif

endmodule : sync_fifo

// File: tb/tb_sync_fifo.sv
// ----------------------------------------------------------------------------
// tb_sync_fifo
//  Randomised and directed stimulus for sync_fifo (WIDTH=8, DEPTH=8).
//  The stimulus side keeps an occupancy model and queues expected flags per
//  cycle plus the expected word order; a monitor on the falling edge compares
//  flags every cycle and pops/compares data whenever the DUT performs a read.
// ----------------------------------------------------------------------------
module tb_sync_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int PTR_W = 4;

    logic clk  = 1'b0;
    logic arst = 1'b1;

    always #5 clk = ~clk;

    sync_fifo_if #(
        .WIDTH (WIDTH)
`ifdef FIFO_STATUS_EN
        ,
        .CNT_W (PTR_W)
`endif
    ) bus ();

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk  (clk),
        .arst (arst),
        .bus  (bus)
    );

    typedef struct packed {
        logic             e;
        logic             f;
        logic [PTR_W-1:0] cnt;
        logic             ov;
        logic             un;
    } exp_t;

    exp_t             flag_q[$];
    logic [WIDTH-1:0] exp_q[$];
    exp_t             mx;

    int               occ     = 0;
    logic             pend_v  = 1'b0;
    logic [WIDTH-1:0] pend_d  = '0;
    logic             prev_ov = 1'b0;
    logic             prev_un = 1'b0;
    int               n_checks = 0;
    int               n_err    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs (caller is just after a rising edge) and
    // record what the FIFO should show during this cycle.
    task automatic drive(input logic w, input logic r, input logic [WIDTH-1:0] d);
        exp_t x;
        bit   wa;
        bit   ra;
        if (pend_v) begin
            exp_q.push_back(pend_d);
            pend_v = 1'b0;
        end
        bus.wr_en   = w;
        bus.rd_en   = r;
        bus.data_in = d;
        wa    = w && (occ < DEPTH);
        ra    = r && (occ > 0);
        x.e   = (occ == 0);
        x.f   = (occ == DEPTH);
        x.cnt = PTR_W'(occ);
        x.ov  = prev_ov;
        x.un  = prev_un;
        flag_q.push_back(x);
        prev_ov = w && (occ == DEPTH);
        prev_un = r && (occ == 0);
        if (wa) begin
            pend_v = 1'b1;
            pend_d = d;
        end
        occ = occ + (wa ? 1 : 0) - (ra ? 1 : 0);
    endtask

    task automatic cycle(input logic w, input logic r, input logic [WIDTH-1:0] d);
        @(posedge clk);
        #1;
        drive(w, r, d);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_empty"}, 32'(bus.empty), 32'd1);
        chk({tag, "_full"}, 32'(bus.full), 32'd0);
        chk({tag, "_data_out"}, 32'(bus.data_out), 32'd0);
`ifdef FIFO_STATUS_EN
        chk({tag, "_count"}, 32'(bus.count), 32'd0);
`endif
    endtask

    // Monitor: flags every cycle, data whenever the DUT pops or holds a head.
    always @(negedge clk) begin
        if (!arst) begin
            if (flag_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL sync: no expectation queued at %0t", $time);
            end else begin
                mx = flag_q.pop_front();
                chk("empty", 32'(bus.empty), 32'(mx.e));
                chk("full", 32'(bus.full), 32'(mx.f));
`ifdef FIFO_STATUS_EN
                chk("count", 32'(bus.count), 32'(mx.cnt));
                chk("overflow", 32'(bus.overflow), 32'(mx.ov));
                chk("underflow", 32'(bus.underflow), 32'(mx.un));
`endif
                if (exp_q.size() == 0) begin
                    chk("data_out_when_empty", 32'(bus.data_out), 32'd0);
                end else begin
                    chk("data_out_head", 32'(bus.data_out), 32'(exp_q[0]));
                    if (bus.rd_en && !bus.empty) begin
                        $display("pop %02h at %0t", bus.data_out, $time);
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b0;
        bus.data_in = '0;

        // 1. reset held for two cycles
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        arst = 1'b0;
        drive(1'b0, 1'b0, '0);

        // 2. fill with 0..9; the last two are dropped
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, WIDTH'(i));
        // 3. drain eight plus two reads on empty
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, '0);

        // 4. wrap-around: three fill/drain rounds
        for (int rep = 0; rep < 3; rep++) begin
            for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, WIDTH'(8'h10 + rep * 8 + i));
            for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, '0);
        end

        // 5. simultaneous read/write at 4, full and empty
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, WIDTH'(8'h40 + i));
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, WIDTH'(8'h50 + i));
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, WIDTH'(8'h60 + i));
        cycle(1'b1, 1'b1, 8'hEE);
        for (int i = 0; i < 7; i++) cycle(1'b0, 1'b1, '0);
        cycle(1'b1, 1'b1, 8'h77);
        cycle(1'b0, 1'b1, '0);

        // 6. asynchronous reset mid-cycle with five words queued
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, WIDTH'(8'hA0 + i));
        @(posedge clk);
        #1;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        #2;
        arst = 1'b1;
        #1;
        check_reset_state("async_reset");
        exp_q.delete();
        occ     = 0;
        pend_v  = 1'b0;
        prev_ov = 1'b0;
        prev_un = 1'b0;
        @(posedge clk);
        #1;
        arst = 1'b0;
        drive(1'b0, 1'b0, '0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, '0);

        // 7. random traffic with a changing read/write bias
        for (int blk = 0; blk < 8; blk++) begin
            int wb;
            int rb;
            wb = (blk % 2 == 0) ? 75 : 35;
            rb = (blk % 2 == 0) ? 35 : 75;
            for (int i = 0; i < 50; i++) begin
                cycle($urandom_range(0, 99) < wb, $urandom_range(0, 99) < rb, WIDTH'($urandom));
            end
        end

        cycle(1'b0, 1'b0, '0);
        cycle(1'b0, 1'b0, '0);
        @(negedge clk);
        #1;
        chk("leftover_flag_expectations", 32'(flag_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule : tb_sync_fifo
